// File: rtl/alu_instr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_instr_sequencer - fetch/execute control strobes for one reg-reg ALU op
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_instr_sequencer #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4,
   parameter int OPC_W     = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                hold,
   input  logic                mem_rdy,
   input  logic [DATA_W-1:0]   ir,
   output logic                pc_out,
   output logic                pc_in,
   output logic                inc_pc,
   output logic                mar_in,
   output logic                read,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                ir_in,
   output logic                y_in,
   output logic                z_in,
   output logic                zlow_out,
   output logic                zhigh_out,
   output logic                hi_in,
   output logic                lo_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [12:0]         alu_sel,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   localparam logic [OPC_W-1:0] c_op_add  = OPC_W'(3);
   localparam logic [OPC_W-1:0] c_op_sub  = OPC_W'(4);
   localparam logic [OPC_W-1:0] c_op_and  = OPC_W'(5);
   localparam logic [OPC_W-1:0] c_op_or   = OPC_W'(6);
   localparam logic [OPC_W-1:0] c_op_ror  = OPC_W'(7);
   localparam logic [OPC_W-1:0] c_op_rol  = OPC_W'(8);
   localparam logic [OPC_W-1:0] c_op_shr  = OPC_W'(9);
   localparam logic [OPC_W-1:0] c_op_shra = OPC_W'(10);
   localparam logic [OPC_W-1:0] c_op_shl  = OPC_W'(11);
   localparam logic [OPC_W-1:0] c_op_mul  = OPC_W'(15);
   localparam logic [OPC_W-1:0] c_op_div  = OPC_W'(16);
   localparam logic [OPC_W-1:0] c_op_neg  = OPC_W'(17);
   localparam logic [OPC_W-1:0] c_op_not  = OPC_W'(18);

   localparam logic [NUM_REGS-1:0] c_reg_one = {{(NUM_REGS-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_DONE  = 4'd8,
      S_ABORT = 4'd9
   } state_t;

   state_t state;
   state_t next_state;

   logic [OPC_W-1:0]     opc;
   logic [REG_SEL_W-1:0] fld_ra;
   logic [REG_SEL_W-1:0] fld_rb;
   logic [REG_SEL_W-1:0] fld_rc;
   logic                 unused_ir;

   assign opc    = ir[DATA_W-1 -: OPC_W];
   assign fld_ra = ir[DATA_W-OPC_W-1 -: REG_SEL_W];
   assign fld_rb = ir[DATA_W-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
   assign fld_rc = ir[DATA_W-OPC_W-2*REG_SEL_W-1 -: REG_SEL_W];
   assign unused_ir = ^ir[DATA_W-OPC_W-3*REG_SEL_W-1:0];

   logic [12:0] dec_alu;
   logic        dec_legal_op;
   logic        dec_unary;
   logic        dec_bad_reg;

   always_comb begin
      dec_alu      = '0;
      dec_legal_op = 1'b1;
      case (opc)
         c_op_and:  dec_alu = 13'h0001;
         c_op_or:   dec_alu = 13'h0002;
         c_op_add:  dec_alu = 13'h0004;
         c_op_sub:  dec_alu = 13'h0008;
         c_op_mul:  dec_alu = 13'h0010;
         c_op_div:  dec_alu = 13'h0020;
         c_op_shr:  dec_alu = 13'h0040;
         c_op_shra: dec_alu = 13'h0080;
         c_op_shl:  dec_alu = 13'h0100;
         c_op_ror:  dec_alu = 13'h0200;
         c_op_rol:  dec_alu = 13'h0400;
         c_op_neg:  dec_alu = 13'h0800;
         c_op_not:  dec_alu = 13'h1000;
         default:   dec_legal_op = 1'b0;
      endcase
   end

   assign dec_unary = dec_alu[11] | dec_alu[12];

   // A register field can only address past the file when the field is wider than needed.
   generate
      if (NUM_REGS < (1 << REG_SEL_W)) begin : g_range_chk
         localparam logic [REG_SEL_W:0] c_nregs = (REG_SEL_W+1)'(NUM_REGS);
         assign dec_bad_reg = ({1'b0, fld_ra} >= c_nregs) |
                              ({1'b0, fld_rb} >= c_nregs) |
                              (!dec_unary && ({1'b0, fld_rc} >= c_nregs));
      end else begin : g_no_range_chk
         assign dec_bad_reg = 1'b0;
      end
   endgenerate

   logic [12:0]          op_alu;
   logic [REG_SEL_W-1:0] op_ra;
   logic [REG_SEL_W-1:0] op_rb;
   logic [REG_SEL_W-1:0] op_rc;
   logic                 op_unary;
   logic                 op_muldiv;

   assign op_unary  = op_alu[11] | op_alu[12];
   assign op_muldiv = op_alu[4]  | op_alu[5];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ir must be stable by T2; the fields are captured as T2 retires so execute steps see a frozen op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_alu <= '0;
         op_ra  <= '0;
         op_rb  <= '0;
         op_rc  <= '0;
      end else if (state == S_T2 && !hold) begin
         op_alu <= dec_alu;
         op_ra  <= fld_ra;
         op_rb  <= fld_rb;
         op_rc  <= fld_rc;
      end
   end

   function automatic logic [NUM_REGS-1:0] reg_dec(input logic [REG_SEL_W-1:0] idx);
      return c_reg_one << idx;
   endfunction

   always_comb begin
      next_state = state;
      pc_out     = 1'b0;
      pc_in      = 1'b0;
      inc_pc     = 1'b0;
      mar_in     = 1'b0;
      read       = 1'b0;
      mdr_in     = 1'b0;
      mdr_out    = 1'b0;
      ir_in      = 1'b0;
      y_in       = 1'b0;
      z_in       = 1'b0;
      zlow_out   = 1'b0;
      zhigh_out  = 1'b0;
      hi_in      = 1'b0;
      lo_in      = 1'b0;
      reg_out    = '0;
      reg_in     = '0;
      alu_sel    = '0;
      done       = 1'b0;
      illegal    = 1'b0;
      busy       = (state != S_IDLE);

      if (state == S_IDLE) begin
         if (start) next_state = S_T0;
      end else if (!hold) begin
         case (state)
            S_T0: begin
               pc_out     = 1'b1;
               mar_in     = 1'b1;
               inc_pc     = 1'b1;
               pc_in      = 1'b1;
               next_state = S_T1;
            end
            S_T1: begin
               read   = 1'b1;
               mdr_in = mem_rdy;
               if (mem_rdy) next_state = S_T2;
            end
            S_T2: begin
               mdr_out = 1'b1;
               ir_in   = 1'b1;
               if (!dec_legal_op || dec_bad_reg) next_state = S_ABORT;
               else if (dec_unary)               next_state = S_T4;
               else                              next_state = S_T3;
            end
            S_T3: begin
               reg_out    = reg_dec(op_rb);
               y_in       = 1'b1;
               next_state = S_T4;
            end
            S_T4: begin
               reg_out    = reg_dec(op_unary ? op_rb : op_rc);
               alu_sel    = op_alu;
               z_in       = 1'b1;
               next_state = S_T5;
            end
            S_T5: begin
               zlow_out = 1'b1;
               if (op_muldiv) begin
                  lo_in      = 1'b1;
                  next_state = S_T6;
               end else begin
                  reg_in     = reg_dec(op_ra);
                  next_state = S_DONE;
               end
            end
            S_T6: begin
               zhigh_out  = 1'b1;
               hi_in      = 1'b1;
               next_state = S_DONE;
            end
            S_DONE: begin
               done       = 1'b1;
               next_state = S_IDLE;
            end
            S_ABORT: begin
               illegal    = 1'b1;
               next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_instr_sequencer - directed + random checks against a phase-list model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_instr_sequencer;

   typedef struct packed {
      logic        pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
      logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
      logic [15:0] reg_out;
      logic [15:0] reg_in;
      logic [12:0] alu_sel;
      logic        busy, done, illegal;
   } strb_t;

   logic        clk = 1'b0;
   logic        reset, start, start8, hold, mem_rdy;
   logic [31:0] ir;

   logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
   logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, busy, done, illegal;
   logic [15:0] reg_out, reg_in;
   logic [12:0] alu_sel;

   logic pc_out_8, pc_in_8, inc_pc_8, mar_in_8, read_8, mdr_in_8, mdr_out_8, ir_in_8;
   logic y_in_8, z_in_8, zlow_out_8, zhigh_out_8, hi_in_8, lo_in_8, busy_8, done_8, illegal_8;
   logic [7:0]  reg_out_8, reg_in_8;
   logic [12:0] alu_sel_8;

   strb_t obs16, obs8;
   int    total = 0;
   int    bad   = 0;
   int    legal_ops[13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};

   always #5 clk = ~clk;

   alu_instr_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .hold(hold), .mem_rdy(mem_rdy), .ir(ir),
      .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .read(read),
      .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
      .zlow_out(zlow_out), .zhigh_out(zhigh_out), .hi_in(hi_in), .lo_in(lo_in),
      .reg_out(reg_out), .reg_in(reg_in), .alu_sel(alu_sel),
      .busy(busy), .done(done), .illegal(illegal)
   );

   alu_instr_sequencer #(.NUM_REGS(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .hold(hold), .mem_rdy(mem_rdy), .ir(ir),
      .pc_out(pc_out_8), .pc_in(pc_in_8), .inc_pc(inc_pc_8), .mar_in(mar_in_8), .read(read_8),
      .mdr_in(mdr_in_8), .mdr_out(mdr_out_8), .ir_in(ir_in_8), .y_in(y_in_8), .z_in(z_in_8),
      .zlow_out(zlow_out_8), .zhigh_out(zhigh_out_8), .hi_in(hi_in_8), .lo_in(lo_in_8),
      .reg_out(reg_out_8), .reg_in(reg_in_8), .alu_sel(alu_sel_8),
      .busy(busy_8), .done(done_8), .illegal(illegal_8)
   );

   assign obs16 = {pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
                   y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in,
                   reg_out, reg_in, alu_sel, busy, done, illegal};
   assign obs8  = {pc_out_8, pc_in_8, inc_pc_8, mar_in_8, read_8, mdr_in_8, mdr_out_8, ir_in_8,
                   y_in_8, z_in_8, zlow_out_8, zhigh_out_8, hi_in_8, lo_in_8,
                   8'h00, reg_out_8, 8'h00, reg_in_8, alu_sel_8, busy_8, done_8, illegal_8};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ALU select bit for each opcode; -1 marks an undefined opcode.
   function automatic int alu_bit(input int opc);
      case (opc)
         3: return 2;    4: return 3;    5: return 0;   6: return 1;
         7: return 9;    8: return 10;   9: return 6;   10: return 7;
         11: return 8;   15: return 4;   16: return 5;  17: return 11;
         18: return 12;  default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 4) != 0) w[31:27] = 5'(legal_ops[$urandom_range(0, 12)]);
      return w;
   endfunction

   function automatic strb_t pick(input bit use8);
      return use8 ? obs8 : obs16;
   endfunction

   // One instruction: build the expected sequence of strobe bundles, then walk it cycle by cycle.
   task automatic run_instr(input logic [31:0] instr, input bit use8, input bit rnd,
                            input int waits, input int hold_ph, input int hold_len,
                            input int rst_ph, output int lat);
      strb_t ph[$];
      strb_t e;
      int    opc, ra, rb, rc, ab, nregs, idx, cyc, w, h;
      bit    unary, md, legal;
      opc = int'(instr[31:27]);
      ra  = int'(instr[26:23]);
      rb  = int'(instr[22:19]);
      rc  = int'(instr[18:15]);
      nregs = use8 ? 8 : 16;
      ab    = alu_bit(opc);
      unary = (ab == 11) || (ab == 12);
      md    = (ab == 4) || (ab == 5);
      legal = (ab >= 0) && (ra < nregs) && (rb < nregs) && (unary || rc < nregs);

      e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.pc_in = 1; ph.push_back(e);
      e = '0; e.busy = 1; e.read = 1; ph.push_back(e);
      e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1; ph.push_back(e);
      if (!legal) begin
         e = '0; e.busy = 1; e.illegal = 1; ph.push_back(e);
      end else begin
         if (!unary) begin
            e = '0; e.busy = 1; e.reg_out = 16'(1 << rb); e.y_in = 1; ph.push_back(e);
         end
         e = '0; e.busy = 1; e.reg_out = 16'(1 << (unary ? rb : rc));
         e.alu_sel = 13'(1 << ab); e.z_in = 1; ph.push_back(e);
         e = '0; e.busy = 1; e.zlow_out = 1;
         if (md) e.lo_in = 1; else e.reg_in = 16'(1 << ra);
         ph.push_back(e);
         if (md) begin
            e = '0; e.busy = 1; e.zhigh_out = 1; e.hi_in = 1; ph.push_back(e);
         end
         e = '0; e.busy = 1; e.done = 1; ph.push_back(e);
      end

      @(negedge clk);
      ir = instr;
      if (use8) start8 = 1'b1; else start = 1'b1;
      hold    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdy = 1'($urandom_range(0, 1));
      #1 check_val("idle_before", pick(use8), '0);

      idx = 0; cyc = 0; w = 0; h = 0; lat = 0;
      while (idx < ph.size()) begin
         @(negedge clk);
         cyc++;
         lat++;
         if (cyc > 400) begin
            check_val("timeout_phase", 64'(idx), 64'(ph.size()));
            break;
         end
         if (rnd) begin
            if (use8) start8 = 1'($urandom_range(0, 1)); else start = 1'($urandom_range(0, 1));
            hold    = ($urandom_range(0, 3) == 0);
            mem_rdy = ($urandom_range(0, 2) != 0);
         end else begin
            start = 1'b0; start8 = 1'b0;
            hold  = 1'b0;
            if (idx == hold_ph && h < hold_len) begin hold = 1'b1; h++; end
            mem_rdy = 1'b1;
            if (idx == 1 && w < waits) begin mem_rdy = 1'b0; w++; end
         end
         #1;
         if (hold) begin
            e = '0; e.busy = 1;
         end else begin
            e = ph[idx];
            if (idx == 1) e.mdr_in = mem_rdy;
         end
         check_val($sformatf("strobes_ph%0d", idx), pick(use8), e);
         if (idx == rst_ph) begin
            #1 reset = 1'b0;
            #1 check_val("async_reset", pick(use8), '0);
            @(negedge clk);
            reset = 1'b1; start = 1'b0; start8 = 1'b0;
            return;
         end
         if (!hold && (idx != 1 || mem_rdy)) idx++;
      end

      @(negedge clk);
      start = 1'b0; start8 = 1'b0;
      hold    = 1'($urandom_range(0, 1));
      mem_rdy = 1'($urandom_range(0, 1));
      #1 check_val("idle_after", pick(use8), '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int lat;
      reset = 1'b0; start = 1'b0; start8 = 1'b0; hold = 1'b0; mem_rdy = 1'b0; ir = '0;
      #3;
      check_val("reset_state16", obs16, '0);
      check_val("reset_state8", obs8, '0);
      @(negedge clk);
      reset = 1'b1;

      run_instr(32'h4A1B8000, 0, 0, 0, -1, 0, -1, lat);  check_val("lat_shr", 64'(lat), 7);
      run_instr(32'h781B8000, 0, 0, 0, -1, 0, -1, lat);  check_val("lat_mul", 64'(lat), 8);
      run_instr(32'h91280000, 0, 0, 0, -1, 0, -1, lat);  check_val("lat_not", 64'(lat), 6);
      run_instr(32'h4A1B8000, 0, 0, 3, -1, 0, -1, lat);  check_val("lat_wait3", 64'(lat), 10);
      run_instr(32'h021B8000, 0, 0, 0, -1, 0, -1, lat);  check_val("lat_illegal_op", 64'(lat), 4);
      run_instr(32'h48C90000, 1, 0, 0, -1, 0, -1, lat);  check_val("lat_illegal_reg", 64'(lat), 4);
      run_instr(32'h18918000, 1, 0, 0, -1, 0, -1, lat);  check_val("lat_restart8", 64'(lat), 7);
      run_instr(32'h80B98000, 0, 0, 0, -1, 0, -1, lat);  check_val("lat_div", 64'(lat), 8);
      run_instr(32'h4A1B8000, 0, 0, 0, 3, 2, -1, lat);   check_val("lat_hold", 64'(lat), 9);
      run_instr(32'h4A1B8000, 0, 0, 0, -1, 0, 4, lat);
      run_instr(32'h4A1B8000, 0, 0, 0, -1, 0, -1, lat);  check_val("lat_after_reset", 64'(lat), 7);

      for (int i = 0; i < 40; i++) run_instr(rand_instr(), 0, 1, 0, -1, 0, -1, lat);
      for (int i = 0; i < 15; i++) run_instr(rand_instr(), 1, 1, 0, -1, 0, -1, lat);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
